// File: rtl/tetris_pkg.sv
//------------------------------------------------------------------------------
// Module : tetris (package)
// Brief  : Move directions and move_avail bit positions shared by game blocks.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tetris;

  typedef enum logic [1:0] {
    eNonDir = 2'd0,
    eDown   = 2'd1,
    eLeft   = 2'd2,
    eRight  = 2'd3
  } direction_e;

  localparam int c_avail_left  = 0;
  localparam int c_avail_right = 1;
  localparam int c_avail_down  = 2;

endpackage

`default_nettype wire

// File: rtl/move_scheduler_gravity_timer.sv
//------------------------------------------------------------------------------
// Module : gravity_timer
// Brief  : Gravity period counter; tick marks the terminal count, reload restarts.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gravity_timer #(
  parameter int gravity_period_p = 25000000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en,
  input  logic reload,
  input  logic period_sel,
  output logic tick
);

  localparam int                 c_width     = $clog2(gravity_period_p);
  localparam logic [c_width-1:0] c_term_slow = c_width'(gravity_period_p - 1);
  localparam logic [c_width-1:0] c_term_fast = c_width'(gravity_period_p / 4 - 1);
  localparam logic [c_width-1:0] c_one       = c_width'(1);

  logic [c_width-1:0] r_count;
  logic [c_width-1:0] w_term;

  assign w_term = period_sel ? c_term_fast : c_term_slow;

  // ">=" makes a count already past a freshly shortened terminal wrap at once.
  assign tick = en && (r_count >= w_term);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (reload || tick) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_scheduler.sv
//------------------------------------------------------------------------------
// Module : move_scheduler
// Brief  : Arbitrates gravity/down/left/right requests into executor issues.
//          Optional macro TETRIS_SOFT_DROP_EN adds btn_down_held_i (period/4).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module move_scheduler
  import tetris::*;
#(
  parameter int gravity_period_p = 25000000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_down_i,
`ifdef TETRIS_SOFT_DROP_EN
  input  logic       btn_down_held_i,
`endif
  input  logic [2:0] move_avail_i,
  output logic       exe_v_o,
  output direction_e exe_direction_o,
  input  logic       exe_done_i,
  output logic       landed_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Pending vector bit positions; higher index wins arbitration.
  localparam int c_pend_right = 0;
  localparam int c_pend_left  = 1;
  localparam int c_pend_down  = 2;
  localparam int c_pend_grav  = 3;

  state_e     r_state;
  logic [3:0] r_pend;
  logic       r_exe_v;
  logic       r_landed;
  direction_e r_dir;

  logic       w_tick;
  logic       w_period_sel;
  logic       w_sel_valid;
  logic       w_sel_legal;
  logic       w_sel_grav;
  logic       w_decide;
  logic       w_reload;
  logic [3:0] w_sel_onehot;
  logic [3:0] w_set;
  logic [3:0] w_clr;
  direction_e w_sel_dir;

`ifdef TETRIS_SOFT_DROP_EN
  assign w_period_sel = btn_down_held_i;
`else
  assign w_period_sel = 1'b0;
`endif

  gravity_timer #(
    .gravity_period_p (gravity_period_p)
  ) u_gravity_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en         (en_i),
    .reload     (w_reload),
    .period_sel (w_period_sel),
    .tick       (w_tick)
  );

  always_comb begin
    w_sel_valid  = 1'b1;
    w_sel_onehot = '0;
    w_sel_dir    = eNonDir;
    w_sel_legal  = 1'b0;
    if (r_pend[c_pend_grav]) begin
      w_sel_onehot[c_pend_grav] = 1'b1;
      w_sel_dir                 = eDown;
      w_sel_legal               = move_avail_i[c_avail_down];
    end else if (r_pend[c_pend_down]) begin
      w_sel_onehot[c_pend_down] = 1'b1;
      w_sel_dir                 = eDown;
      w_sel_legal               = move_avail_i[c_avail_down];
    end else if (r_pend[c_pend_left]) begin
      w_sel_onehot[c_pend_left] = 1'b1;
      w_sel_dir                 = eLeft;
      w_sel_legal               = move_avail_i[c_avail_left];
    end else if (r_pend[c_pend_right]) begin
      w_sel_onehot[c_pend_right] = 1'b1;
      w_sel_dir                  = eRight;
      w_sel_legal                = move_avail_i[c_avail_right];
    end else begin
      w_sel_valid = 1'b0;
    end
  end

  assign w_sel_grav = r_pend[c_pend_grav];
  assign w_decide   = en_i && (r_state == IDLE) && w_sel_valid;
  // Any serviced gravity step, issued or landed, restarts the period.
  assign w_reload   = w_decide && w_sel_grav;
  assign w_clr      = w_decide ? w_sel_onehot : 4'b0000;
  assign w_set      = {w_tick, btn_down_i, btn_left_i, btn_right_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_pend <= '0;
    end else if (!en_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= IDLE;
      r_exe_v  <= 1'b0;
      r_landed <= 1'b0;
      r_dir    <= eNonDir;
    end else begin
      r_exe_v  <= 1'b0;
      r_landed <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_decide) begin
            if (w_sel_legal) begin
              r_state <= ISSUE;
              r_exe_v <= 1'b1;
              r_dir   <= w_sel_dir;
            end else begin
              r_landed <= w_sel_grav;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (exe_done_i) begin
            r_state <= IDLE;
            r_dir   <= eNonDir;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dir   <= eNonDir;
        end
      endcase
    end
  end

  assign exe_v_o         = r_exe_v;
  assign landed_o        = r_landed;
  assign exe_direction_o = r_dir;
  assign busy_o          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_move_scheduler.sv
//------------------------------------------------------------------------------
// Module : tb_move_scheduler
// Brief  : Randomized scoreboard bench for move_scheduler (default build).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_move_scheduler;
  import tetris::*;

  localparam int PERIOD = 8;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       en_i;
  logic       btn_left_i;
  logic       btn_right_i;
  logic       btn_down_i;
  logic [2:0] move_avail_i;
  logic       exe_done_i;
  logic       exe_v_o;
  logic       landed_o;
  logic       busy_o;
  direction_e exe_direction_o;

  move_scheduler #(
    .gravity_period_p (PERIOD)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .en_i            (en_i),
    .btn_left_i      (btn_left_i),
    .btn_right_i     (btn_right_i),
    .btn_down_i      (btn_down_i),
`ifdef TETRIS_SOFT_DROP_EN
    .btn_down_held_i (1'b0),
`endif
    .move_avail_i    (move_avail_i),
    .exe_v_o         (exe_v_o),
    .exe_direction_o (exe_direction_o),
    .exe_done_i      (exe_done_i),
    .landed_o        (landed_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    direction_e dir;
  } issue_t;

  issue_t q_issue[$];
  int     q_land[$];

  // Reference model. Request slots in priority order: 0 gravity, 1 down, 2 left, 3 right.
  // m_phase: 0 no operation, 1 issue cycle, 2 waiting for the executor.
  int         m_cyc = 0;
  int         m_count;
  int         m_phase;
  int         m_since;
  bit         m_pend[4];
  direction_e m_dir;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic direction_e dir_of(input int slot);
    case (slot)
      0, 1:    return eDown;
      2:       return eLeft;
      default: return eRight;
    endcase
  endfunction

  function automatic int avail_of(input int slot);
    case (slot)
      0, 1:    return 2;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
  endtask

  task automatic model_reset();
    m_count = 0;
    m_phase = 0;
    m_since = 0;
    m_dir   = eNonDir;
    for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    q_issue.delete();
    q_land.delete();
  endtask

  task automatic model_step();
    bit setb[4];
    bit clr[4];
    bit tick;
    int sel;
    m_cyc++;
    if (reset_i) begin
      model_reset();
      return;
    end
    tick = 1'b0;
    if (en_i) begin
      if (m_count == PERIOD - 1) begin
        tick    = 1'b1;
        m_count = 0;
      end else begin
        m_count++;
      end
    end
    setb = '{tick, btn_down_i, btn_left_i, btn_right_i};
    for (int i = 0; i < 4; i++) clr[i] = 1'b0;
    m_since++;
    if (m_phase == 0) begin
      if (en_i) begin
        sel = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) sel = i;
        if (sel >= 0) begin
          clr[sel] = 1'b1;
          if (sel == 0) m_count = 0;
          if (move_avail_i[avail_of(sel)]) begin
            m_phase = 1;
            m_dir   = dir_of(sel);
            m_since = 0;
            q_issue.push_back('{m_cyc, dir_of(sel)});
          end else if (sel == 0) begin
            q_land.push_back(m_cyc);
          end
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (exe_done_i) begin
      m_phase = 0;
      m_dir   = eNonDir;
    end
    for (int i = 0; i < 4; i++) m_pend[i] = en_i && ((m_pend[i] && !clr[i]) || setb[i]);
  endtask

  function automatic bit auto_done(input int k);
    return (m_phase == 2) && (m_since >= k);
  endfunction

  task automatic drive(input bit rst, input bit en, input bit l, input bit r, input bit d,
                       input logic [2:0] av, input bit done);
    @(negedge clk_i);
    reset_i      = rst;
    en_i         = en;
    btn_left_i   = l;
    btn_right_i  = r;
    btn_down_i   = d;
    move_avail_i = av;
    exe_done_i   = done;
    @(posedge clk_i);
    model_step();
  endtask

  task automatic drive_random(input bit allow_done);
    drive(1'b0, $urandom_range(0, 19) != 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
          {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0},
          allow_done && ($urandom_range(0, 2) == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_exe_v"}, 32'(exe_v_o), 32'(0));
    chk({tag, "_landed"}, 32'(landed_o), 32'(0));
    chk({tag, "_dir"}, 32'(exe_direction_o), 32'(eNonDir));
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
  endtask

  // Monitor: compares DUT outputs with model state and pops scoreboard events.
  initial begin : monitor
    bit exp_v;
    bit exp_l;
    forever begin
      @(negedge clk_i);
      chk("busy", 32'(busy_o), 32'(m_phase != 0));
      chk("direction", 32'(exe_direction_o), 32'(m_dir));
      exp_v = (q_issue.size() > 0) && (q_issue[0].cyc == m_cyc);
      chk("exe_v", 32'(exe_v_o), 32'(exp_v));
      if (exp_v) begin
        chk("issue_dir", 32'(exe_direction_o), 32'(q_issue[0].dir));
        void'(q_issue.pop_front());
      end
      exp_l = (q_land.size() > 0) && (q_land[0] == m_cyc);
      chk("landed", 32'(landed_o), 32'(exp_l));
      if (exp_l) void'(q_land.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    bit reached;
    reset_i      = 1'b1;
    en_i         = 1'b0;
    btn_left_i   = 1'b0;
    btn_right_i  = 1'b0;
    btn_down_i   = 1'b0;
    move_avail_i = 3'b000;
    exe_done_i   = 1'b0;
    model_reset();

    // Reset held with activity on the inputs.
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1);
    #1;
    check_reset_outputs("reset");

    // Free-running gravity with all moves legal.
    repeat (60) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, auto_done(2));

    // Left and right pulsed together.
    for (int i = 0; i < 20 && m_phase != 0; i++)
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, auto_done(2));
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0);
    repeat (30) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, auto_done(2));

    // Down illegal: gravity lands instead of issuing.
    repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, auto_done(1));

    // Right illegal: request dropped.
    for (int i = 0; i < 20 && m_phase != 0; i++)
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, auto_done(1));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b101, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, auto_done(1));

    // Disabled game: buttons arrive but nothing should queue.
    repeat (40) drive(1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, 3'b111, $urandom_range(0, 1) == 1);

    // Random traffic.
    repeat (3000) drive_random(1'b1);

    // Asynchronous reset while waiting on the executor.
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      drive(1'b0, 1'b1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0, 3'b111, 1'b0);
      reached = (m_phase == 2);
    end
    chk("reach_wait", 32'(reached), 32'(1));
    #2;
    reset_i = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
    repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b111, auto_done(2));

    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 1'b1);
    @(negedge clk_i);
    #1;
    chk("issue_queue_drained", 32'(q_issue.size()), 32'(0));
    chk("landed_queue_drained", 32'(q_land.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
